// File: rtl/reg_dump_reader_if.sv
// Register-file read ports plus the dump output stream, as seen between the
// dump reader (master) and the register file / stream consumer (slave).
interface reg_dump_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output rd_addr_a,
    output rd_addr_b,
    input  rd_data_a,
    input  rd_data_b,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_last
  );

  modport slave (
    input  rd_addr_a,
    input  rd_addr_b,
    output rd_data_a,
    output rd_data_b,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_last
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Debug dump engine: walks the register file two registers per fetch through
// its combinational read ports and streams each word out with its index.
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  reg_dump_reader_if.master bus
);

  // One extra bit so ptr can reach NUM_REGS without wrapping.
  localparam int unsigned PtrW = ADDR_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   ptr_q;
  logic              sel_q;
  logic [ADDR_W-1:0] idx_base_q;
  logic [DATA_W-1:0] buf0_q;
  logic [DATA_W-1:0] buf1_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;

  logic              hs;
  logic              last_pair;
  logic [ADDR_W-1:0] index;

  assign hs        = valid_q & bus.out_ready;
  assign last_pair = (ptr_q == PtrW'(NUM_REGS));
  assign index     = idx_base_q + ADDR_W'(sel_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      sel_q      <= 1'b0;
      idx_base_q <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
    end else if (abort && (state_q != StIdle)) begin
      // Abort beats any handshake this cycle; the word in flight is dropped.
      state_q  <= StIdle;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StFetch;
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            addr_a_q <= '0;
            addr_b_q <= ADDR_W'(1);
          end
        end
        StFetch: begin
          buf0_q     <= bus.rd_data_a;
          buf1_q     <= bus.rd_data_b;
          idx_base_q <= ptr_q[ADDR_W-1:0];
          ptr_q      <= ptr_q + PtrW'(2);
          sel_q      <= 1'b0;
          valid_q    <= 1'b1;
          addr_a_q   <= '0;
          addr_b_q   <= '0;
          state_q    <= StDrain;
        end
        StDrain: begin
          if (hs) begin
            if (!sel_q) begin
              sel_q <= 1'b1;
            end else if (last_pair) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Present the next pair's addresses during the coming FETCH.
              state_q  <= StFetch;
              valid_q  <= 1'b0;
              addr_a_q <= ptr_q[ADDR_W-1:0];
              addr_b_q <= ptr_q[ADDR_W-1:0] + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ptr_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.rd_addr_a = addr_a_q;
  assign bus.rd_addr_b = addr_b_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = sel_q ? buf1_q : buf0_q;
  assign bus.out_index = index;
  assign bus.out_last  = valid_q && (index == ADDR_W'(NUM_REGS - 1));

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register-file model, stream monitor and
// hand-computed expectations for full dump, backpressure, snapshot, abort,
// asynchronous reset and start-while-busy.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        out_ready = 1'b0;
  int          ready_mode;
  int          stall_idx;

  logic [31:0] regs [32];
  logic [31:0] exp_val [32];

  logic [31:0] got_data [$];
  int          got_idx [$];
  int          done_cnt = 0;
  int          last_viol = 0;
  int          stall_viol = 0;
  int          stalls_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [4:0]  prev_idx = '0;

  int          n_tests = 0;
  int          n_fail = 0;

  reg_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  reg_dump_reader #(
    .NUM_REGS(32),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) u_dut (
    .clk  (clk),
    .reset(rst_n),
    .start(start),
    .abort(abort),
    .busy (busy),
    .done (done),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.rd_data_a = regs[bus.rd_addr_a];
  assign bus.rd_data_b = regs[bus.rd_addr_b];
  assign bus.out_ready = out_ready;

  // Consumer ready: 0 = held low, 1 = high except on stall_idx, else alternate.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = !(bus.out_valid && (32'(bus.out_index) == stall_idx));
      default: out_ready = ~out_ready;
    endcase
  end

  always @(negedge clk) begin
    if (bus.out_valid && out_ready) begin
      got_data.push_back(bus.out_data);
      got_idx.push_back(32'(bus.out_index));
      if (bus.out_last != (bus.out_index == 5'd31)) last_viol <= last_viol + 1;
    end
    if (prev_stall && bus.out_valid &&
        ((bus.out_data != prev_data) || (bus.out_index != prev_idx))) begin
      stall_viol <= stall_viol + 1;
    end
    if (prev_stall) stalls_seen <= stalls_seen + 1;
    if (done) done_cnt <= done_cnt + 1;
    prev_stall <= bus.out_valid && !out_ready;
    prev_data  <= bus.out_data;
    prev_idx   <= bus.out_index;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_index(input int idx);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.out_valid && (32'(bus.out_index) == idx)) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("wait_index", 32'(ok), 32'd1);
  endtask

  task automatic check_dump(input string tag, input int base, input int dbase);
    int mism = 0;
    check_eq({tag, "_beats"}, 32'(got_data.size() - base), 32'd32);
    for (int k = 0; (k < 32) && (base + k < got_data.size()); k++) begin
      if ((got_data[base+k] !== exp_val[k]) || (got_idx[base+k] != k)) mism++;
    end
    check_eq({tag, "_order"}, 32'(mism), 32'd0);
    check_eq({tag, "_done_cnt"}, 32'(done_cnt - dbase), 32'd1);
    check_eq({tag, "_last"}, 32'(last_viol), 32'd0);
    check_eq({tag, "_stable"}, 32'(stall_viol), 32'd0);
  endtask

  task automatic full_dump(input string tag);
    int base;
    int dbase;
    int n;
    base  = got_data.size();
    dbase = done_cnt;
    pulse_start();
    wait_done(0, n);
    @(negedge clk);
    check_dump(tag, base, dbase);
  endtask

  initial begin
    int base;
    int dbase;
    int n;
    int s0;

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    ready_mode = 1;
    stall_idx  = -1;
    for (int i = 0; i < 32; i++) begin
      regs[i]    = 32'(3 * i);
      exp_val[i] = 32'(3 * i);
    end
    repeat (2) @(negedge clk);

    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_addr_a", 32'(bus.rd_addr_a), 32'd0);
    check_eq("rst_addr_b", 32'(bus.rd_addr_b), 32'd0);
    check_eq("rst_data", bus.out_data, 32'd0);
    check_eq("rst_index", 32'(bus.out_index), 32'd0);
    check_eq("rst_last", 32'(bus.out_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full dump with latency checks; done is captured at the 49th edge.
    base  = got_data.size();
    dbase = done_cnt;
    pulse_start();
    check_eq("fetch_busy", 32'(busy), 32'd1);
    check_eq("fetch_valid", 32'(bus.out_valid), 32'd0);
    check_eq("fetch_addr_a", 32'(bus.rd_addr_a), 32'd0);
    check_eq("fetch_addr_b", 32'(bus.rd_addr_b), 32'd1);
    @(negedge clk);
    check_eq("first_valid", 32'(bus.out_valid), 32'd1);
    check_eq("first_index", 32'(bus.out_index), 32'd0);
    check_eq("first_data", bus.out_data, 32'd0);
    wait_done(1, n);
    check_eq("done_latency", 32'(n + 1), 32'd49);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_dump("full", base, dbase);
    if (got_data.size() == base + 32) begin
      check_eq("full_last_data", got_data[base+31], 32'd93);
    end

    // Backpressure: ready on alternate cycles.
    ready_mode = 2;
    s0 = stalls_seen;
    full_dump("bp");
    check_eq("bp_stalled", 32'(stalls_seen - s0 >= 16), 32'd1);
    ready_mode = 1;
    repeat (2) @(negedge clk);

    // Snapshot: write reg[5] while pair (4,5) drains.
    base  = got_data.size();
    dbase = done_cnt;
    pulse_start();
    wait_index(4);
    regs[5] = 32'hDEADBEEF;
    wait_done(0, n);
    @(negedge clk);
    check_dump("snap1", base, dbase);
    if (got_data.size() > base + 5) check_eq("snap_old", got_data[base+5], 32'd15);
    exp_val[5] = 32'hDEADBEEF;
    base = got_data.size();
    full_dump("snap2");
    if (got_data.size() > base + 5) check_eq("snap_new", got_data[base+5], 32'hDEADBEEF);
    regs[5]    = 32'd15;
    exp_val[5] = 32'd15;

    // Abort while index 10 is valid but not accepted.
    stall_idx = 10;
    base  = got_data.size();
    dbase = done_cnt;
    pulse_start();
    wait_index(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("abort_beats", 32'(got_data.size() - base), 32'd10);
    check_eq("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    stall_idx = -1;
    full_dump("restart");

    // Asynchronous reset mid-DRAIN, between clock edges.
    pulse_start();
    wait_index(7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_data", bus.out_data, 32'd0);
    check_eq("arst_addr_a", 32'(bus.rd_addr_a), 32'd0);
    check_eq("arst_addr_b", 32'(bus.rd_addr_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_dump("post_rst");

    // Start while busy is ignored.
    base  = got_data.size();
    dbase = done_cnt;
    pulse_start();
    wait_index(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, n);
    @(negedge clk);
    check_dump("busy_start", base, dbase);
    repeat (3) @(negedge clk);
    check_eq("no_restart", 32'(busy), 32'd0);
    check_eq("no_extra_beats", 32'(got_data.size() - base), 32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug read-out engine for the MIPS register file.
- On a start pulse it walks all architectural registers through the file's two combinational read ports, two registers per fetch.
- Each fetched pair is snapshotted into a 2-entry buffer and streamed out one word per valid/ready handshake, tagged with its register index.
- It is the reader end of the register-file interface and replaces simulation-only register printing with a synthesizable dump path.

Parameters:
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1); must be even and at least 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
- start  input  1  one-cycle dump request; sampled only in IDLE.
- abort  input  1  cancel the dump in progress.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.
- rd_addr_a  output  ADDR_W  to register-file read port A (rs).
- rd_addr_b  output  ADDR_W  to register-file read port B (rt).
- rd_data_a  input  DATA_W  combinational read data for rd_addr_a.
- rd_data_b  input  DATA_W  combinational read data for rd_addr_b.
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer ready.
- out_data  output  DATA_W  register value.
- out_index  output  ADDR_W  register index of out_data.
- out_last  output  1  high with the word for index NUM_REGS-1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ptr=0, sel=0, both buffer entries=0. All outputs are 0, including rd_addr_a/b, out_data and out_index.
- FSM states are IDLE, FETCH, DRAIN and DONE.
- IDLE:
  - rd_addr_a=rd_addr_b=0, out_valid=0.
  - start=1 -> FETCH, ptr=0.
- FETCH (exactly 1 cycle):
  - rd_addr_a=ptr, rd_addr_b=ptr+1.
  - At the edge: buf0<=rd_data_a, buf1<=rd_data_b, idx_base<=ptr, ptr<=ptr+2, sel<=0 -> DRAIN.
- DRAIN:
  - out_valid=1, out_data=sel?buf1:buf0, out_index=idx_base+sel.
  - out_last=1 iff out_index==NUM_REGS-1.
  - Handshake = out_valid & out_ready.
  - Handshake with sel=0 -> sel<=1.
  - Handshake with sel=1: if ptr==NUM_REGS -> DONE, else -> FETCH.
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last are held stable.
- DONE: done=1 for exactly one cycle, busy=1, then -> IDLE.
- Snapshot semantics: buffered values are fixed at the FETCH edge. Register writes after capture do not alter emitted data. A write to a fetched address coincident with FETCH returns whatever the file presents combinationally that cycle; no bypass is provided.
- Latency: start sampled at edge T -> FETCH during cycle T+1 -> first out_valid in cycle T+2.
- Throughput: with out_ready held at 1, one pair takes 3 cycles. A full dump is 3*NUM_REGS/2 cycles from FETCH entry to the final handshake, and done follows in the next cycle.
- ptr width is ADDR_W+1, so the comparison with NUM_REGS=32 does not wrap. out_index never exceeds NUM_REGS-1.
- start while busy=1 is ignored.
- abort=1 in FETCH, DRAIN or DONE -> IDLE at the next edge:
  - out_valid drops, no done pulse, ptr<=0.
  - abort has priority over a simultaneous handshake; the word in flight counts as not delivered.
- abort in IDLE has no effect. abort and start together in IDLE -> start wins.
- Reset asserted mid-dump forces IDLE and zeroes outputs without waiting for clk. After release, the next start dumps from index 0.

Test Plan:
- Full dump: preload reg[i]=3*i (reg[0]=0), out_ready=1, pulse start -> 32 beats with out_index 0..31 and out_data 0,3,...,93; out_last only on index 31; done high for one cycle, 49 cycles after start's edge; busy low afterwards.
- Backpressure: out_ready high on alternate cycles only -> same 32 values in order; out_data and out_index are stable every cycle valid=1 & ready=0; no word is duplicated or dropped.
- Snapshot: during the DRAIN of pair (4,5), write reg[5]=0xDEADBEEF -> index 5 emits the old value 15; a second dump emits 0xDEADBEEF.
- Abort: assert abort while out_index=10 is valid and unaccepted -> IDLE next cycle, out_valid=0, no done; restart -> dump begins at index 0.
- Async reset: drive reset low mid-DRAIN between clock edges -> busy, out_valid, out_data and rd_addr_a/b are 0 before the next edge; after release, start -> correct full dump.
- Start while busy: pulse start at index 20 -> no restart; the dump completes with exactly 32 beats and one done pulse.
